// File: rtl/arb_pkg.sv
// Shared definitions for the eight-way round-robin arbiter: sizes, the
// FSM state type and the rotating-priority pick function.
package arb_pkg;

  localparam int N_REQ        = 8;
  localparam int IDX_W        = 3;
  localparam int MAX_HOLD_DEF = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Scan req starting at ptr and wrapping (ptr, ptr+1, ..., 7, 0, ..., ptr-1).
  // When mask_en is set, bit mask_idx is ignored so a timed-out owner can
  // give way. Returns {found, idx}; idx is 0 when nothing is found.
  function automatic logic [IDX_W:0] rr_pick(
    input logic [N_REQ-1:0] req,
    input logic [IDX_W-1:0] ptr,
    input logic [IDX_W-1:0] mask_idx,
    input logic             mask_en
  );
    logic [N_REQ-1:0] eff;
    logic             found;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] cand;
    eff = req;
    if (mask_en) eff[mask_idx] = 1'b0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = ptr + IDX_W'(i);
      if (!found && eff[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    return {found, idx};
  endfunction

endpackage

// File: rtl/grant_decoder.sv
// 3-to-8 one-hot decoder with enable; all-zero output when disabled, so the
// result can never be multi-hot.
module grant_decoder
  import arb_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  input  logic             en,
  output logic [N_REQ-1:0] onehot
);

  // Decode the index into a single set bit, gated by the enable.
  always_comb begin
    onehot = '0;
    if (en) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for eight requesters. The owner keeps the grant while
// it requests, for at most MAX_HOLD consecutive cycles when others are
// waiting. All outputs are registered; gnt is the decoded next-state index.
module rr_arbiter8 #(
  parameter int N_REQ    = arb_pkg::N_REQ,
  parameter int IDX_W    = arb_pkg::IDX_W,
  parameter int MAX_HOLD = arb_pkg::MAX_HOLD_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid
);

  import arb_pkg::*;

  localparam int HOLD_W = $clog2(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  // Registered state. state_q is the FSM state that checkers bind to.
  arb_state_t        state_q, state_n;
  logic [IDX_W-1:0]  ptr_q, ptr_n;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_n;
  logic [IDX_W-1:0]  idx_q, idx_n;
  logic              valid_q, valid_n;
  logic [N_REQ-1:0]  gnt_q, gnt_n;

  // Arbitration candidates: plain scan, and scan with the owner masked out.
  logic [IDX_W:0] pick_all;
  logic [IDX_W:0] pick_mask;
  logic           owner_req;

  assign pick_all  = rr_pick(req, ptr_q, idx_q, 1'b0);
  assign pick_mask = rr_pick(req, ptr_q, idx_q, 1'b1);
  assign owner_req = req[idx_q];

  // Next-state, pointer, tenure counter and grant index selection.
  always_comb begin
    state_n    = state_q;
    ptr_n      = ptr_q;
    hold_cnt_n = hold_cnt_q;
    idx_n      = idx_q;
    valid_n    = valid_q;
    unique case (state_q)
      IDLE: begin
        if (pick_all[IDX_W]) begin
          state_n    = GRANT;
          idx_n      = pick_all[IDX_W-1:0];
          valid_n    = 1'b1;
          ptr_n      = pick_all[IDX_W-1:0] + IDX_W'(1);
          hold_cnt_n = '0;
        end
      end
      GRANT: begin
        if (!owner_req) begin
          // Release takes priority over timeout; the owner bit is low so an
          // unmasked scan already excludes it.
          if (pick_all[IDX_W]) begin
            idx_n      = pick_all[IDX_W-1:0];
            ptr_n      = pick_all[IDX_W-1:0] + IDX_W'(1);
            hold_cnt_n = '0;
          end else begin
            state_n    = IDLE;
            valid_n    = 1'b0;
            hold_cnt_n = '0;
          end
        end else if (hold_cnt_q != HOLD_LAST) begin
          hold_cnt_n = hold_cnt_q + HOLD_W'(1);
        end else begin
          // Tenure expired: hand off if anyone else waits, otherwise the
          // owner keeps the grant with a fresh tenure and ptr untouched.
          hold_cnt_n = '0;
          if (pick_mask[IDX_W]) begin
            idx_n = pick_mask[IDX_W-1:0];
            ptr_n = pick_mask[IDX_W-1:0] + IDX_W'(1);
          end
        end
      end
      default: begin
        state_n = IDLE;
        valid_n = 1'b0;
      end
    endcase
  end

  // Output stage: decode the next-state index so gnt registers alongside it.
  grant_decoder u_grant_decoder (
    .idx    (idx_n),
    .en     (valid_n),
    .onehot (gnt_n)
  );

  // State, pointer, counter and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      hold_cnt_q <= '0;
      idx_q      <= '0;
      valid_q    <= 1'b0;
      gnt_q      <= '0;
    end else begin
      state_q    <= state_n;
      ptr_q      <= ptr_n;
      hold_cnt_q <= hold_cnt_n;
      idx_q      <= idx_n;
      valid_q    <= valid_n;
      gnt_q      <= gnt_n;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = idx_q;
  assign gnt_valid = valid_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed bench for rr_arbiter8 with hand-computed expected grants.
module tb_rr_arbiter8;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;

  int n_checks;
  int n_fail;

  rr_arbiter8 #(.MAX_HOLD(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  // Clock: 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value with its expected value.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Check the full output set; the index only matters when valid.
  task automatic expect_out(input string tag, input logic [7:0] exp_gnt,
                            input logic exp_valid, input logic [2:0] exp_idx);
    check({tag, ".gnt"}, 32'(gnt), 32'(exp_gnt));
    check({tag, ".valid"}, 32'(gnt_valid), 32'(exp_valid));
    if (exp_valid) check({tag, ".idx"}, 32'(gnt_idx), 32'(exp_idx));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 8'h00;
    step(1);
    rst = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    req = 8'h00;

    // Reset held 3 cycles, then idle for 10 cycles.
    step(3);
    expect_out("reset", 8'h00, 1'b0, 3'd0);
    check("reset.idx0", 32'(gnt_idx), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      expect_out("idle", 8'h00, 1'b0, 3'd0);
    end

    // Single requester 2, released after 5 cycles; next scan starts at 3.
    req = 8'h04;
    step(1);
    expect_out("single", 8'h04, 1'b1, 3'd2);
    for (int i = 0; i < 4; i++) begin
      step(1);
      expect_out("single_hold", 8'h04, 1'b1, 3'd2);
    end
    req = 8'h00;
    step(1);
    expect_out("single_rel", 8'h00, 1'b0, 3'd0);
    req = 8'h0C;
    step(1);
    expect_out("ptr3", 8'h08, 1'b1, 3'd3);

    // All requesting: 0..7 then 0, 16 cycles each, no gaps.
    do_reset();
    req = 8'hFF;
    step(1);
    for (int g = 0; g < 9; g++) begin
      for (int c = 0; c < 16; c++) begin
        expect_out("rr_all", 8'(1 << (g % 8)), 1'b1, 3'(g % 8));
        step(1);
      end
    end
    expect_out("rr_wrap", 8'h02, 1'b1, 3'd1);

    // Owner 6 releases while 7 and 0 request: direct handoff to 7, then 0.
    do_reset();
    req = 8'h40;
    step(1);
    expect_out("own6", 8'h40, 1'b1, 3'd6);
    req = 8'h81;
    step(1);
    expect_out("hand7", 8'h80, 1'b1, 3'd7);
    req = 8'h01;
    step(1);
    expect_out("hand0", 8'h01, 1'b1, 3'd0);

    // Lone requester 3 keeps the grant through timeouts at 16 and 32.
    do_reset();
    req = 8'h08;
    step(1);
    expect_out("lone_first", 8'h08, 1'b1, 3'd3);
    for (int i = 0; i < 40; i++) begin
      step(1);
      expect_out("lone_hold", 8'h08, 1'b1, 3'd3);
    end

    // Reset mid-grant, then first arbitration from ptr 0.
    do_reset();
    req = 8'h20;
    step(1);
    expect_out("pre_rst", 8'h20, 1'b1, 3'd5);
    rst = 1'b1;
    req = 8'h81;
    step(1);
    expect_out("mid_rst", 8'h00, 1'b0, 3'd0);
    check("mid_rst.idx0", 32'(gnt_idx), 32'd0);
    rst = 1'b0;
    step(1);
    expect_out("post_rst", 8'h01, 1'b1, 3'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
